booth_result_fifo: RTL and testbench

Port-mapped result buffer downstream of the Booth multiplier. It captures each 16-bit signed product when the multiplier's done rises and pushes it into a small FIFO. It also keeps a running signed sum of the accepted products. The PicoBlaze reads products, status and the sum through INPUT ports, and clears the block through an OUTPUT command port, at a base address that does not overlap the multiplier's 0x80-0x82 ports.

---
 rtl/booth_result_fifo.sv | 171 +++++++++++++++++
 tb/tb_booth_result_fifo.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_result_fifo.sv
// booth_result_fifo: port-mapped result buffer behind the Booth multiplier.
// Captures each signed 16-bit product on the rising edge of done into a small
// FIFO and keeps a wrapping signed running sum of every accepted product.
// PicoBlaze map (offsets from BASE):
//   +0 head MSB, +1 head LSB (read_strobe pops), +2 status / command,
//   +3..+5 accumulator bytes, sign-extended above ACC_W.
// Optional feature macro: BOOTH_FIFO_IRQ_EN adds a registered irq output.
module booth_result_fifo #(
   parameter int         DEPTH = 4,
   parameter int         ACC_W = 24,
   parameter logic [7:0] BASE  = 8'h90
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        done,
   input  logic [15:0] result,
   input  logic [7:0]  port_id,
   input  logic        read_strobe,
   input  logic        write_strobe,
   input  logic [7:0]  out_port,
   output logic [7:0]  rd_data
`ifdef BOOTH_FIFO_IRQ_EN
   ,
   output logic        irq
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [7:0]    ADDR_LSB = BASE + 8'd1;
   localparam logic [7:0]    ADDR_CMD = BASE + 8'd2;

   logic                    done_q_r;
   logic [PW-1:0]           wr_ptr_r;
   logic [PW-1:0]           rd_ptr_r;
   logic [CW-1:0]           count_r;
   logic                    ovf_r;
   logic signed [ACC_W-1:0] acc_r;
   logic [15:0]             mem_r [DEPTH];

   logic                    capture_s;
   logic                    empty_s;
   logic                    full_s;
   logic                    pop_s;
   logic                    push_s;
   logic                    drop_s;
   logic                    clr_fifo_s;
   logic                    clr_acc_s;
   logic signed [15:0]      result_s;
   logic [15:0]             head_s;
   logic [3:0]              count_ext_s;
   logic signed [23:0]      acc_ext_s;
   logic [7:0]              status_s;
   logic [7:0]              offset_s;

   assign capture_s   = done & ~done_q_r;
   assign empty_s     = (count_r == {CW{1'b0}});
   assign full_s      = (count_r == DEPTH_C);
   assign pop_s       = read_strobe & (port_id == ADDR_LSB) & ~empty_s;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign push_s      = capture_s & (~full_s | pop_s);
   assign drop_s      = capture_s & full_s & ~pop_s;
   assign clr_fifo_s  = write_strobe & (port_id == ADDR_CMD) & out_port[0];
   assign clr_acc_s   = write_strobe & (port_id == ADDR_CMD) & out_port[1];
   assign result_s    = result;
   assign head_s      = empty_s ? 16'h0000 : mem_r[rd_ptr_r];
   assign count_ext_s = 4'(count_r);
   assign acc_ext_s   = 24'(acc_r);
   assign status_s    = {ovf_r, count_ext_s[2:0], 2'b00, full_s, empty_s};
   assign offset_s    = port_id - BASE;

   // Register done; reset high so a done already asserted at release is ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q_r <= 1'b1;
      end else begin
         done_q_r <= done;
      end
   end

   // Pointer, occupancy and sticky overflow control; a FIFO clear wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         ovf_r    <= 1'b0;
      end else if (clr_fifo_s) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         ovf_r    <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         if (push_s && !pop_s) begin
            count_r <= count_r + CW'(1);
         end else if (pop_s && !push_s) begin
            count_r <= count_r - CW'(1);
         end else begin
            count_r <= count_r;
         end
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else begin
            ovf_r <= ovf_r;
         end
      end
   end

   // Product storage, written at the write pointer on every accepted capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 16'h0000;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= result;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

   // Wrapping signed running sum of accepted products; accumulator clear wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_r <= '0;
      end else if (clr_acc_s) begin
         acc_r <= '0;
      end else if (push_s) begin
         acc_r <= acc_r + ACC_W'(result_s);
      end else begin
         acc_r <= acc_r;
      end
   end

   // Combinational read mux for the PicoBlaze in_port path.
   always_comb begin
      rd_data = 8'h00;
      case (offset_s)
         8'd0:    rd_data = head_s[15:8];
         8'd1:    rd_data = head_s[7:0];
         8'd2:    rd_data = status_s;
         8'd3:    rd_data = acc_ext_s[7:0];
         8'd4:    rd_data = acc_ext_s[15:8];
         8'd5:    rd_data = acc_ext_s[23:16];
         default: rd_data = 8'h00;
      endcase
   end

`ifdef BOOTH_FIFO_IRQ_EN
   // Interrupt request follows pending data or overflow one cycle later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq <= 1'b0;
      end else begin
         irq <= (count_r != {CW{1'b0}}) | ovf_r;
      end
   end
`endif

endmodule

// File: tb/tb_booth_result_fifo.sv
// Self-checking bench for booth_result_fifo (default build, DEPTH=4, ACC_W=24,
// BASE=8'h90). A queue-based reference model predicts rd_data for the current
// port_id and is compared on every falling edge; directed sequences pin the
// model with hand-computed literal values, then a randomized phase follows.
module tb_booth_result_fifo;

   localparam int         DEPTH = 4;
   localparam logic [7:0] BASE  = 8'h90;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        done = 1'b0;
   logic [15:0] result = 16'h0000;
   logic [7:0]  port_id = 8'h00;
   logic        read_strobe = 1'b0;
   logic        write_strobe = 1'b0;
   logic [7:0]  out_port = 8'h00;
   logic [7:0]  rd_data;

   int errors = 0;
   int checks = 0;

   booth_result_fifo #(.DEPTH(DEPTH), .ACC_W(24), .BASE(BASE)) dut (
      .clk          (clk),
      .reset        (reset),
      .done         (done),
      .result       (result),
      .port_id      (port_id),
      .read_strobe  (read_strobe),
      .write_strobe (write_strobe),
      .out_port     (out_port),
      .rd_data      (rd_data)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [15:0] m_q[$];
   logic        m_ovf;
   logic [23:0] m_acc;
   logic        m_done_q;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q.delete();
         m_ovf    = 1'b0;
         m_acc    = 24'h000000;
         m_done_q = 1'b1;
      end else begin
         bit cap, pop, full, accept, wcmd;
         cap      = done && !m_done_q;
         m_done_q = done;
         full     = (m_q.size() == DEPTH);
         pop      = read_strobe && (port_id == BASE + 8'd1) && (m_q.size() > 0);
         accept   = cap && (!full || pop);
         wcmd     = write_strobe && (port_id == BASE + 8'd2);
         if (cap && !accept) m_ovf = 1'b1;
         if (pop) void'(m_q.pop_front());
         if (accept) begin
            m_q.push_back(result);
            m_acc = m_acc + {{8{result[15]}}, result};
         end
         if (wcmd && out_port[0]) begin
            m_q.delete();
            m_ovf = 1'b0;
         end
         if (wcmd && out_port[1]) m_acc = 24'h000000;
      end
   end

   function automatic logic [7:0] model_rd(input logic [7:0] pid);
      logic [15:0] head;
      logic [2:0]  cnt;
      int          off;
      head = (m_q.size() > 0) ? m_q[0] : 16'h0000;
      cnt  = 3'(m_q.size());
      off  = int'(pid) - int'(BASE);
      if (off == 0) return head[15:8];
      if (off == 1) return head[7:0];
      if (off == 2) return {m_ovf, cnt, 2'b00, (m_q.size() == DEPTH), (m_q.size() == 0)};
      if (off == 3) return m_acc[7:0];
      if (off == 4) return m_acc[15:8];
      if (off == 5) return m_acc[23:16];
      return 8'h00;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: port_id=%02h got %02h expected %02h at %0t",
                  name, port_id, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model on every falling edge.
   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) check("model", rd_data, model_rd(port_id));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input logic [7:0] pid, input logic [7:0] exp, input string name);
      port_id = pid;
      #1;
      check(name, rd_data, exp);
   endtask

   task automatic capture(input logic [15:0] v);
      result = v;
      done   = 1'b1;
      tick();
      done   = 1'b0;
      tick();
   endtask

   task automatic pop_chk(input logic [7:0] exp_msb, input logic [7:0] exp_lsb, input string name);
      rd_chk(BASE, exp_msb, {name, "_msb"});
      read_strobe = 1'b1;
      rd_chk(BASE + 8'd1, exp_lsb, {name, "_lsb"});
      tick();
      read_strobe = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] v);
      port_id      = BASE + 8'd2;
      out_port     = v;
      write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0;
      out_port     = 8'h00;
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      cmp_en = 1'b1;
      reset  = 1'b1;
      tick();
      rd_chk(BASE + 8'd2, 8'h01, "reset_status");
      rd_chk(BASE + 8'd0, 8'h00, "reset_msb");
      rd_chk(BASE + 8'd3, 8'h00, "reset_acc0");
      rd_chk(BASE + 8'd4, 8'h00, "reset_acc1");
      rd_chk(BASE + 8'd5, 8'h00, "reset_acc2");

      // Single capture with done held five cycles
      result = 16'h0C35;
      done   = 1'b1;
      repeat (5) tick();
      done = 1'b0;
      tick();
      rd_chk(BASE + 8'd2, 8'h10, "one_capture_status");
      pop_chk(8'h0C, 8'h35, "pop_0c35");
      rd_chk(BASE + 8'd2, 8'h01, "after_pop_status");

      // Signed accumulation and FIFO order
      cmd(8'h02);
      capture(16'hFFFE);
      capture(16'h0005);
      rd_chk(BASE + 8'd3, 8'h03, "acc_b0");
      rd_chk(BASE + 8'd4, 8'h00, "acc_b1");
      rd_chk(BASE + 8'd5, 8'h00, "acc_b2");
      pop_chk(8'hFF, 8'hFE, "pop_fffe");
      pop_chk(8'h00, 8'h05, "pop_0005");

      // Overflow after five captures
      cmd(8'h03);
      for (int i = 1; i <= 5; i++) capture(16'(i));
      rd_chk(BASE + 8'd2, 8'hC2, "overflow_status");
      rd_chk(BASE + 8'd3, 8'h0A, "overflow_acc_excludes_5th");
      rd_chk(BASE + 8'd1, 8'h01, "overflow_head");
      cmd(8'h01);
      rd_chk(BASE + 8'd2, 8'h01, "clear_status");

      // Full FIFO: capture and pop on the same edge
      cmd(8'h03);
      capture(16'h0011);
      capture(16'h0022);
      capture(16'h0033);
      capture(16'h0044);
      result      = 16'h0055;
      done        = 1'b1;
      read_strobe = 1'b1;
      rd_chk(BASE + 8'd1, 8'h11, "simul_pop_lsb");
      tick();
      done        = 1'b0;
      read_strobe = 1'b0;
      tick();
      rd_chk(BASE + 8'd2, 8'h42, "simul_status");
      pop_chk(8'h00, 8'h22, "simul_pop22");
      pop_chk(8'h00, 8'h33, "simul_pop33");
      pop_chk(8'h00, 8'h44, "simul_pop44");
      pop_chk(8'h00, 8'h55, "simul_pop55");

      // Asynchronous reset mid-sequence, done high through release
      cmd(8'h03);
      capture(16'h0100);
      capture(16'h0023);
      rd_chk(BASE + 8'd3, 8'h23, "pre_reset_acc0");
      rd_chk(BASE + 8'd4, 8'h01, "pre_reset_acc1");
      #1;
      reset = 1'b0;
      done  = 1'b1;
      rd_chk(BASE + 8'd2, 8'h01, "async_reset_status");
      rd_chk(BASE + 8'd4, 8'h00, "async_reset_acc1");
      tick();
      reset = 1'b1;
      repeat (3) tick();
      rd_chk(BASE + 8'd2, 8'h01, "no_capture_after_reset");
      done = 1'b0;
      tick();

      // Randomized phase checked by the model at every falling edge
      for (int n = 0; n < 3000; n++) begin
         done         = ($urandom_range(0, 2) == 0);
         result       = 16'($urandom());
         port_id      = 8'($urandom_range(8'h8E, 8'h97));
         read_strobe  = ($urandom_range(0, 1) == 1);
         write_strobe = ($urandom_range(0, 11) == 0);
         out_port     = 8'($urandom());
         if ($urandom_range(0, 499) == 0) reset = 1'b0;
         tick();
         reset = 1'b1;
      end
      done         = 1'b0;
      read_strobe  = 1'b0;
      write_strobe = 1'b0;
      tick();
      cmp_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
